// File: rtl/dmem_arbiter_if.sv
// Bundle of the pipeline, debug and memory-side signals around the data memory arbiter.
// "slave" is the arbiter's view; "master" is the surrounding requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int B = 32
);
    logic         p_req;
    logic         p_we;
    logic [B-1:0] p_addr;
    logic [B-1:0] p_wdata;
    logic         p_stall;
    logic         p_rvalid;
    logic [B-1:0] p_rdata;

    logic         d_req;
    logic         d_we;
    logic [B-1:0] d_addr;
    logic [B-1:0] d_wdata;
    logic         d_gnt;
    logic         d_rvalid;
    logic [B-1:0] d_rdata;

    logic         mem_en;
    logic [3:0]   mem_we;
    logic [B-1:0] mem_addr;
    logic [B-1:0] mem_wdata;
    logic [B-1:0] mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output p_stall, p_rvalid, p_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  p_stall, p_rvalid, p_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: the pipeline has priority,
// and a starvation counter forces a debug slot after STARVE consecutive waiting cycles.
module dmem_arbiter #(
    parameter int B      = 32,
    parameter int STARVE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus
);
    localparam logic [3:0] STARVE_CNT = 4'(STARVE);

    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic       tag_valid_reg, tag_valid_next;
    logic       tag_owner_reg, tag_owner_next;

    logic       grant_d, grant_p;
    logic       win_we;

    // Arbitration is suppressed while reset is asserted so the memory port stays quiet.
    always_comb begin
        grant_d = rst_n & bus.d_req & (~bus.p_req | (wait_cnt_reg == STARVE_CNT));
        grant_p = rst_n & bus.p_req & ~grant_d;
    end

    always_comb begin
        win_we        = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (grant_d) begin
            win_we        = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (grant_p) begin
            win_we        = bus.p_we;
            bus.mem_addr  = bus.p_addr;
            bus.mem_wdata = bus.p_wdata;
        end
        bus.mem_en  = grant_p | grant_d;
        bus.mem_we  = {4{win_we}};
        bus.d_gnt   = grant_d;
        bus.p_stall = rst_n & bus.p_req & ~grant_p;
    end

    // Waiting count clears on a debug grant or when debug drops its request.
    always_comb begin
        wait_cnt_next = 4'd0;
        if (bus.d_req && !grant_d) begin
            if (wait_cnt_reg >= STARVE_CNT)
                wait_cnt_next = STARVE_CNT;
            else
                wait_cnt_next = wait_cnt_reg + 4'd1;
        end
        tag_valid_next = bus.mem_en & ~bus.mem_we[0];
        tag_owner_next = grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg  <= 4'd0;
            tag_valid_reg <= 1'b0;
            tag_owner_reg <= 1'b0;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            tag_valid_reg <= tag_valid_next;
            tag_owner_reg <= tag_owner_next;
        end
    end

    always_comb begin
        bus.p_rvalid = tag_valid_reg & ~tag_owner_reg;
        bus.d_rvalid = tag_valid_reg &  tag_owner_reg;
        bus.p_rdata  = bus.mem_rdata;
        bus.d_rdata  = bus.mem_rdata;
    end
endmodule
